// File: rtl/switch_emu_pkg.sv
// -----------------------------------------------------------------------------
// switch_emu_pkg
// Shared types and constants for the switch bounce emulator.
//   state_e     : per-bit FSM state (IDLE / BOUNCE)
//   LFSR_WIDTH  : width of the shared noise generator
//   LFSR_POLY   : Galois feedback mask (right-shifting form)
//   lfsr_step() : one Galois shift of the noise generator
// -----------------------------------------------------------------------------
package switch_emu_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_BOUNCE = 1'b1
  } state_e;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 16'hB400;

  // Right shift; when the bit falling out is 1, fold the polynomial back in.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    lfsr_step = {1'b0, s[LFSR_WIDTH-1:1]} ^ ({LFSR_WIDTH{s[0]}} & LFSR_POLY);
  endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// -----------------------------------------------------------------------------
// lfsr_galois16
// Free-running 16-bit Galois LFSR used as the chatter noise source. It shifts
// on every clock regardless of what the consumers are doing.
// Ports:
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset, loads the seed
//   ov_lfsr : current LFSR state
// -----------------------------------------------------------------------------
module lfsr_galois16
  import switch_emu_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] p_SEED = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [LFSR_WIDTH-1:0] ov_lfsr
);

  // An all-zero state is a lock-up state for the LFSR, so a zero seed is
  // replaced by 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_SAFE =
    (p_SEED == '0) ? 16'h0001 : p_SEED;

  logic [LFSR_WIDTH-1:0] lfsr_q;

  // NOTE: sequential state uses non-blocking assignments and the reset sits in
  // the sensitivity list, so reset takes effect without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q <= SEED_SAFE;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign ov_lfsr = lfsr_q;

endmodule

// File: rtl/switch_bounce_emulator.sv
// -----------------------------------------------------------------------------
// switch_bounce_emulator
// Inverse of a switch debouncer: turns a clean level vector into a bouncing
// one. After each level change a bit emits pseudo-random noise for iv_len
// cycles and then settles to the new level.
// Ports:
//   i_clk     : clock
//   i_rst     : asynchronous active-high reset
//   i_en      : 1 = emulate bounce, 0 = pass changes through with 1 cycle latency
//   iv_len    : bounce length in cycles, sampled when a bounce starts/restarts
//   iv_input  : clean level vector
//   ov_output : registered bouncing output
//   ov_busy   : per bit, high while that bit is bouncing
// -----------------------------------------------------------------------------
module switch_bounce_emulator
  import switch_emu_pkg::*;
#(
  parameter int unsigned           p_WIDTH      = 1,
  parameter int unsigned           p_CNT_WIDTH  = 4,
  parameter logic                  p_INIT_VALUE = 1'b0,
  parameter logic [LFSR_WIDTH-1:0] p_LFSR_SEED  = 16'hACE1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [p_CNT_WIDTH-1:0] iv_len,
  input  logic [p_WIDTH-1:0]     iv_input,
  output logic [p_WIDTH-1:0]     ov_output,
  output logic [p_WIDTH-1:0]     ov_busy
);

  logic [LFSR_WIDTH-1:0] lfsr_state;

  lfsr_galois16 #(
    .p_SEED (p_LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .ov_lfsr (lfsr_state)
  );

  // Only the low p_WIDTH taps feed the bits; the rest are intentionally unused.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_state;

  localparam logic [p_CNT_WIDTH-1:0] CNT_ONE = p_CNT_WIDTH'(1);

  for (genvar b = 0; b < p_WIDTH; b++) begin : g_bit
    state_e                 state_q, state_d;
    logic [p_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   tgt_q, tgt_d;
    logic                   chg;
    logic                   noise;
    logic                   len_zero;

    assign chg      = (iv_input[b] != tgt_q);
    assign noise    = lfsr_state[b];
    assign len_zero = (iv_len == '0);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      tgt_d   = tgt_q;

      unique case (state_q)
        ST_IDLE: begin
          if (chg) begin
            tgt_d = iv_input[b];
            if (i_en && !len_zero) begin
              cnt_d   = iv_len;
              state_d = ST_BOUNCE;
              out_d   = noise;
            end else begin
              out_d = iv_input[b];
            end
          end else begin
            out_d = tgt_q;
          end
        end

        ST_BOUNCE: begin
          if (!i_en) begin
            // Abort wins over everything else while bouncing.
            state_d = ST_IDLE;
            out_d   = iv_input[b];
            tgt_d   = iv_input[b];
          end else if (chg) begin
            // Restart with a freshly sampled length.
            tgt_d = iv_input[b];
            if (len_zero) begin
              state_d = ST_IDLE;
              out_d   = iv_input[b];
            end else begin
              cnt_d = iv_len;
              out_d = noise;
            end
          end else if (cnt_q == CNT_ONE) begin
            // Exit at 1 so the counter never has to pass through 0.
            state_d = ST_IDLE;
            out_d   = tgt_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            out_d = noise;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        out_q   <= p_INIT_VALUE;
        tgt_q   <= p_INIT_VALUE;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        tgt_q   <= tgt_d;
      end
    end

    assign ov_output[b] = out_q;
    assign ov_busy[b]   = (state_q == ST_BOUNCE);
  end

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// -----------------------------------------------------------------------------
// tb_switch_bounce_emulator
// Directed self-checking bench for switch_bounce_emulator (4 bits, init 1).
// A local LFSR model advanced once per clock edge supplies the expected
// noise value for each bouncing bit.
// -----------------------------------------------------------------------------
module tb_switch_bounce_emulator;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [CW-1:0] len = '0;
  logic [W-1:0]  din = 4'hF;
  logic [W-1:0]  dout;
  logic [W-1:0]  busy;

  switch_bounce_emulator #(
    .p_WIDTH      (W),
    .p_CNT_WIDTH  (CW),
    .p_INIT_VALUE (1'b1),
    .p_LFSR_SEED  (16'hACE1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .iv_len    (len),
    .iv_input  (din),
    .ov_output (dout),
    .ov_busy   (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_lfsr;  // model of the DUT LFSR before the next edge
  logic [15:0] n;       // LFSR value the DUT used at the most recent edge
  int          busy_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Advance one clock edge; inputs may be changed right after return.
  task automatic step();
    n = m_lfsr;
    @(posedge clk);
    #1;
    m_lfsr = model_next(m_lfsr);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_lfsr = 16'hACE1;
    check("rst_out",  32'(dout), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_lfsr", 32'(dut.lfsr_state), 32'hACE1);

    // ---------------- bypass (en=0, then len=0) ----------------
    din = 4'h5;
    #1;
    check("byp_latency", 32'(dout), 32'hF);
    step();
    check("byp_out_5", 32'(dout), 32'h5);
    check("byp_busy_5", 32'(busy), 32'h0);
    din = 4'hA;
    step();
    check("byp_out_A", 32'(dout), 32'hA);
    en  = 1'b1;
    len = '0;
    din = 4'h0;
    step();
    check("byp_len0_out", 32'(dout), 32'h0);
    check("byp_len0_busy", 32'(busy), 32'h0);

    // ---------------- basic bounce, L=5 on bit 0 ----------------
    len = 4'd5;
    din = 4'h1;
    step();
    check("bb_noise0", 32'(dout[0]), 32'(n[0]));
    check("bb_busy0", 32'(busy), 32'h1);
    len = 4'd2;  // must not affect the running bounce
    for (int k = 1; k < 5; k++) begin
      step();
      check($sformatf("bb_noise%0d", k), 32'(dout[0]), 32'(n[0]));
      check($sformatf("bb_busy%0d", k), 32'(busy), 32'h1);
      check($sformatf("bb_others%0d", k), 32'(dout[3:1]), 32'h0);
    end
    step();
    check("bb_settle", 32'(dout), 32'h1);
    check("bb_idle", 32'(busy), 32'h0);

    // ---------------- restart, L=8 on bit 1 ----------------
    len         = 4'd8;
    din         = 4'h3;
    busy_cycles = 0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) din = 4'h1;
      step();
      if (busy[1]) busy_cycles++;
      check($sformatf("rs_bit0_%0d", k), 32'(dout[0]), 32'h1);
      if (k <= 10) check($sformatf("rs_noise%0d", k), 32'(dout[1]), 32'(n[1]));
      else         check($sformatf("rs_settle%0d", k), 32'(dout), 32'h1);
    end
    check("rs_busy_total", 32'(busy_cycles), 32'd11);

    // ---------------- abort, bits 0 and 2, L=6 ----------------
    len = 4'd6;
    din = 4'h4;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ab_b0_%0d", k), 32'(dout[0]), 32'(n[0]));
      check($sformatf("ab_b2_%0d", k), 32'(dout[2]), 32'(n[2]));
      check($sformatf("ab_b13_%0d", k), 32'({dout[3], dout[1]}), 32'h0);
      check($sformatf("ab_busy%0d", k), 32'(busy), 32'h5);
    end
    en = 1'b0;
    step();
    check("ab_out", 32'(dout), 32'h4);
    check("ab_busy", 32'(busy), 32'h0);

    // ---------------- independence, same bits, en held ----------------
    en  = 1'b1;
    din = 4'h1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("in_b0_%0d", k), 32'(dout[0]), 32'(n[0]));
      check($sformatf("in_b2_%0d", k), 32'(dout[2]), 32'(n[2]));
      check($sformatf("in_b13_%0d", k), 32'({dout[3], dout[1]}), 32'h0);
      check($sformatf("in_busy%0d", k), 32'(busy), 32'h5);
    end
    step();
    check("in_settle", 32'(dout), 32'h1);
    check("in_idle", 32'(busy), 32'h0);

    // ---------------- shortest bounce, L=1 on bit 3 ----------------
    len = 4'd1;
    din = 4'h9;
    step();
    check("l1_noise", 32'(dout[3]), 32'(n[3]));
    check("l1_busy", 32'(busy), 32'h8);
    step();
    check("l1_settle", 32'(dout), 32'h9);
    check("l1_idle", 32'(busy), 32'h0);

    // ---------------- asynchronous reset mid-bounce ----------------
    len = 4'd15;
    din = 4'h0;
    step();
    check("mr_busy_pre", 32'(busy), 32'h9);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mr_out", 32'(dout), 32'hF);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_lfsr", 32'(dut.lfsr_state), 32'hACE1);
    #1;
    rst    = 1'b0;
    m_lfsr = 16'hACE1;
    step();
    check("mr_restart_out", 32'(dout), 32'(n[3:0]));
    check("mr_restart_busy", 32'(busy), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switch_bounce_emulator.md
Name: switch_bounce_emulator

Overview:
Synthesizable inverse of the switch debouncer. It takes a clean per-bit level vector and re-creates contact chatter: after every level change, each bit toggles pseudo-randomly for a programmable number of cycles, then settles to the new level. It is used on-board and in benches to drive the debouncer with realistic bouncing stimulus, and it sits directly in front of the debouncer input.

Parameters:
p_WIDTH, 1, width of the input/output vector; range 1..16.
p_CNT_WIDTH, 4, width of the bounce-length input and of the per-bit counters. Maximum bounce is 2^p_CNT_WIDTH-1 cycles.
p_INIT_VALUE, 1'b0, reset value replicated into every output and target bit.
p_LFSR_SEED, 16'hACE1, LFSR reset value. A seed of 0 is replaced by 16'h0001.

Ports:
i_clk  input  1  clock.
i_rst  input  1  reset, asynchronous, active-high. All state registers are cleared on posedge i_clk or posedge i_rst.
i_en  input  1  1 = emulate bounce; 0 = pass changes through after one cycle of latency.
iv_len  input  p_CNT_WIDTH  bounce length L in cycles. It is sampled on every edge where a bounce starts or restarts. L = 0 means no bounce.
iv_input  input  p_WIDTH  clean level vector.
ov_output  output  p_WIDTH  bouncing output (registered).
ov_busy  output  p_WIDTH  per bit: 1 while that bit is in the BOUNCE state (decoded from the state register).

Behaviour:
- Reset values: rv_output = rv_target = {p_WIDTH{p_INIT_VALUE}}; every counter = 0; every state = IDLE; ov_busy = 0; lfsr = p_LFSR_SEED (or 1 if the seed is 0).
- LFSR: 16-bit Galois, polynomial mask 16'hB400. It shifts right every cycle regardless of i_en or bit activity. Noise bit for bit b is lfsr[b].
- Each bit has an independent 2-state FSM (IDLE, BOUNCE), a counter rv_cnt[b] and a target register rv_target[b]. "chg" means iv_input[b] != rv_target[b].
- IDLE, chg, i_en=1, iv_len!=0: rv_target <= iv_input[b]; rv_cnt <= iv_len; state <= BOUNCE; rv_output <= noise.
- IDLE, chg, (i_en=0 or iv_len=0): rv_target <= iv_input[b]; rv_output <= iv_input[b]; stay in IDLE. Latency is 1 cycle.
- IDLE, no chg: rv_output <= rv_target.
- BOUNCE, i_en=0: state <= IDLE; rv_output <= iv_input[b]; rv_target <= iv_input[b]. Abort has priority over every other BOUNCE rule.
- BOUNCE, chg: restart. rv_target <= iv_input[b]; rv_cnt <= iv_len, or go straight to IDLE with rv_output <= iv_input[b] if iv_len = 0; otherwise rv_output <= noise.
- BOUNCE, no chg, rv_cnt == 1: state <= IDLE; rv_output <= rv_target.
- BOUNCE, no chg, rv_cnt > 1: rv_cnt <= rv_cnt - 1; rv_output <= noise.
- Timing for a change sampled at edge t with L != 0: output is noise on edges t..t+L-1 (exactly L noisy values) and equals the new level from edge t+L. ov_busy is high for cycles t+1..t+L.
- Noise values may coincide with the target level; there is no guarantee of toggling.
- Bits never interact except through the shared LFSR.
- Reset asserted mid-bounce: all outputs return to their reset values immediately, without waiting for a clock edge.
- iv_len changing during a bounce has no effect until the next start or restart.
- Counter arithmetic is unsigned, p_CNT_WIDTH bits. The counter never wraps because the 1 -> IDLE exit comes before 0.

Decomposition:
- Package switch_emu_pkg holds:
  - the state enum (ST_IDLE = 1'b0, ST_BOUNCE = 1'b1);
  - LFSR_POLY = 16'hB400;
  - LFSR_WIDTH = 16.
- Sub-module lfsr_galois16 contains the seeded, free-running LFSR with asynchronous reset. It exposes the 16-bit state and has a zero-seed guard.
- The per-bit FSM is generated in a generate loop inside the top module; it is not a separate module.

Test Plan:
- Reset check: p_INIT_VALUE = 1, i_rst pulsed mid-cycle -> ov_output = all 1s and ov_busy = 0 before the next edge; lfsr = 16'hACE1.
- Basic bounce: i_en = 1, iv_len = 5, iv_input[0] goes 0 -> 1 at edge t -> ov_output[0] follows lfsr[0] on edges t..t+4, is 1 from edge t+5 onward, and ov_busy[0] is high for exactly 5 cycles.
- Bypass: i_en = 0 (or iv_len = 0), iv_input toggles -> ov_output equals iv_input delayed by 1 cycle and ov_busy stays 0.
- Restart: iv_len = 8, input rises, then falls 3 cycles later -> bounce restarts with a full 8 cycles, output settles at 0, and total busy time is 11 cycles.
- Abort and independence: p_WIDTH = 4, bits 0 and 2 change on the same edge with iv_len = 6, and i_en drops at cycle 3 -> both bits settle to the input the next edge and bits 1 and 3 stay constant. Repeat with i_en held high -> each bit's noise matches its own LFSR tap.
- End-to-end: emulator drives a debouncer with p_CNT_WIDTH = 4, iv_len = 10, on 100 random level changes spaced more than 40 cycles apart -> the debouncer output changes exactly once per input change.
